// File: rtl/pwm_from_count.sv
//==============================================================================
// Module   : pwm_from_count
// Purpose  : Registered PWM from a running count with a double-buffered duty
//            value and a saturating completed-period counter.
//            Optional macro PWM_FULLSCALE_EN: all-ones duty gives 100% high.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module pwm_from_count #(
  parameter int countWidth  = 8,
  parameter int periodWidth = 16
) (
  input  logic                   iClk,
  input  logic                   _iReset,
  input  logic [countWidth-1:0]  iCount,
  input  logic                   iOverflow,
  input  logic                   iEnable,
  input  logic [countWidth-1:0]  iDutyVal,
  input  logic                   iDutyValid,
  output logic                   oDutyReady,
  output logic                   oPwm,
  output logic                   oPending,
  output logic [periodWidth-1:0] oPeriodCnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [countWidth-1:0]   duty_act_q, duty_act_d;
  logic [countWidth-1:0]   duty_sh_q, duty_sh_d;
  logic                    pwm_q, pwm_d;
  logic                    ovf_prev_q;
  logic [periodWidth-1:0]  period_q, period_d;
  logic                    boundary;
  logic                    xfer;

  assign boundary   = iOverflow & ~ovf_prev_q;
  assign oDutyReady = (state_q != PEND);
  assign oPending   = (state_q == PEND);
  assign xfer       = iDutyValid & oDutyReady;
  assign oPwm       = pwm_q;
  assign oPeriodCnt = period_q;

  always_comb begin
    state_d    = state_q;
    duty_act_d = duty_act_q;
    duty_sh_d  = duty_sh_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) duty_act_d = iDutyVal;
        if (iEnable) state_d = RUN;
      end
      RUN: begin
        // A transfer coinciding with disable goes straight to active so it is not lost.
        if (!iEnable) begin
          state_d = IDLE;
          if (xfer) duty_act_d = iDutyVal;
        end else if (xfer) begin
          duty_sh_d = iDutyVal;
          state_d   = PEND;
        end
      end
      PEND: begin
        if (!iEnable) begin
          duty_act_d = duty_sh_q;
          state_d    = IDLE;
        end else if (boundary) begin
          duty_act_d = duty_sh_q;
          state_d    = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pwm_d = 1'b0;
    if (state_q != IDLE) begin
`ifdef PWM_FULLSCALE_EN
      pwm_d = (&duty_act_q) | (iCount < duty_act_q);
`else
      pwm_d = (iCount < duty_act_q);
`endif
    end
  end

  always_comb begin
    period_d = period_q;
    if (boundary && (state_q != IDLE) && !(&period_q))
      period_d = period_q + 1'b1;
  end

  always_ff @(posedge iClk or negedge _iReset) begin
    if (!_iReset) begin
      state_q    <= IDLE;
      duty_act_q <= '0;
      duty_sh_q  <= '0;
      pwm_q      <= 1'b0;
      ovf_prev_q <= 1'b0;
      period_q   <= '0;
    end else begin
      state_q    <= state_d;
      duty_act_q <= duty_act_d;
      duty_sh_q  <= duty_sh_d;
      pwm_q      <= pwm_d;
      ovf_prev_q <= iOverflow;
      period_q   <= period_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/pwm_from_count.md
Name: pwm_from_count

Overview:
- Downstream consumer of the 8-bit up/down counter's count and overflow outputs.
- Turns the running count into a registered PWM waveform by comparing it against a duty value.
- The duty value is double-buffered. A new value is accepted through a valid/ready handshake and takes effect only at a period boundary, which is a rising edge of the counter's overflow.
- Also counts completed periods for software or debug readback.

Parameters:
- countWidth, 8, width of iCount, iDutyVal and the duty registers.
- periodWidth, 16, width of oPeriodCnt.

Ports:
- iClk  input  1  system clock; all state updates on the rising edge.
- _iReset  input  1  asynchronous, active-low reset.
- iCount  input  countWidth  running count from the counter stage.
- iOverflow  input  1  overflow flag from the counter stage, treated as a level.
- iEnable  input  1  1 = generate PWM, 0 = idle.
- iDutyVal  input  countWidth  new duty value.
- iDutyValid  input  1  iDutyVal is valid this cycle.
- oDutyReady  output  1  block can accept a duty value this cycle.
- oPwm  output  1  registered PWM output.
- oPending  output  1  a shadow duty value is waiting for a period boundary.
- oPeriodCnt  output  periodWidth  number of completed periods; saturates.

Behaviour:
- Reset (_iReset=0, asynchronous) sets:
  - state to IDLE;
  - oPwm, oPending, oPeriodCnt, the active duty and the shadow duty to 0;
  - the internal previous-overflow register to 0.
- Boundary event: iOverflow=1 and previous-overflow register=0, sampled on the same edge. The previous-overflow register loads iOverflow every cycle.
- Handshake:
  - oDutyReady is 1 in IDLE and RUN and 0 in PEND. It is decoded combinationally from the state.
  - A transfer occurs on an edge where iDutyValid=1 and oDutyReady=1.
  - iDutyVal must be held while iDutyValid=1 and oDutyReady=0.
- State machine (IDLE, RUN, PEND):
  - IDLE: oPwm=0. A transfer writes the active duty directly. iEnable=1 moves to RUN.
  - RUN:
    - A transfer writes the shadow duty and moves to PEND. If that same cycle is a boundary, the new value is not committed at this boundary; it waits for the next one.
    - iEnable=0 moves to IDLE.
  - PEND: a boundary copies shadow to active and moves to RUN. oDutyReady returns to 1 on the following cycle.
  - Disable from PEND (iEnable=0): shadow is copied to active immediately and the state goes to IDLE. A pending value is never lost.
- oPending = (state==PEND), decoded from state.
- PWM compare:
  - In RUN or PEND, oPwm is registered from (iCount < active duty), an unsigned compare. Latency is 1 clock from iCount.
  - In IDLE, oPwm is registered to 0.
  - Count direction does not matter: the compare is purely on value.
- Duty boundary values:
  - Duty 0: oPwm is always 0.
  - Duty all-ones: oPwm is 0 only when iCount is all-ones (but see Optional Feature).
- Period counter:
  - Increments by 1 on each boundary while in RUN or PEND.
  - Holds in IDLE.
  - Saturates at all-ones and never wraps.
- Reset mid-PEND discards the shadow value. After reset the active duty is 0.

Optional Feature:
- Macro: PWM_FULLSCALE_EN.
- Defined: active duty all-ones forces oPwm=1 for every count in RUN/PEND, giving 100% duty.
- Not defined: the plain compare applies, so the maximum duty is (2^countWidth − 1)/2^countWidth.
- Duty 0 gives oPwm=0 in both builds.

Test Plan:
1. Reset and idle: hold _iReset=0, then release with iEnable=0 and iCount sweeping 0..255 → oPwm=0, oPeriodCnt=0, oDutyReady=1, oPending=0 throughout.
2. Load in IDLE, then run: in IDLE transfer duty 64, set iEnable=1, drive iCount 0..255 with an overflow pulse at each wrap → oPwm=1 for 64 cycles and 0 for 192 (delayed 1 clock); oPeriodCnt increments by 1 per overflow.
3. Double-buffer commit: in RUN at duty 64, transfer 200 mid-period → oPending=1, oDutyReady=0, and the period stays at 64 high. After the next overflow rising edge: oPending=0 and the next period is 200 high.
4. Transfer on a boundary cycle: transfer 32 on the same edge as an overflow rising edge → stays PEND; duty 32 takes effect only after the following overflow.
5. Disable while pending, then reset mid-pending:
   - Transfer 100 in RUN, then drop iEnable before any overflow → IDLE with active duty 100. Re-enable → 100 high cycles per period.
   - Separately, assert _iReset while PEND → all outputs 0 and active duty 0.
6. Edge values:
   - Duty 0 → oPwm constant 0.
   - Duty 255 → oPwm low only at count 255; with PWM_FULLSCALE_EN, constantly 1.
   - Preload oPeriodCnt to 0xFFFE and apply 3 overflows → saturates at 0xFFFF.
